// File: rtl/quantize_seq_pkg.sv
// Shared definitions for the quantize stage and the SRAM write-out stage that consumes its
// matrix_index/data_set sideband.
package quantize_seq_pkg;

    localparam int MATRIX_INDEX_W     = 6;
    localparam int DATA_SET_W         = 2;
    localparam int DEFAULT_ARRAY_SIZE = 32;
    localparam int MAX_DIAG           = 2 * DEFAULT_ARRAY_SIZE - 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Index of the last anti-diagonal for a given array dimension.
    function automatic int max_diag(input int array_size);
        return 2 * array_size - 2;
    endfunction

endpackage

// File: rtl/quantize_seq_quant_lane.sv
// One lane of the quantizer: round-half-up arithmetic right shift, then saturate to the
// output width. Purely combinational; the parent registers the result.
module quant_lane #(
    parameter int ACC_WIDTH         = 32,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int SHIFT             = 8
) (
    input  logic [ACC_WIDTH-1:0]         acc_i,
    output logic [OUTPUT_DATA_WIDTH-1:0] q_o
);

    localparam int AW = ACC_WIDTH;
    localparam int OW = OUTPUT_DATA_WIDTH;

    localparam logic signed [AW:0] RND  = {{AW{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [AW:0] MAXV = {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

    logic signed [AW:0] ext;
    logic signed [AW:0] sum;
    logic signed [AW:0] shifted;

    // One guard bit keeps the rounding add from overflowing at the positive extreme.
    assign ext     = {acc_i[AW-1], acc_i};
    assign sum     = ext + RND;
    assign shifted = sum >>> SHIFT;

    always_comb begin
        q_o = shifted[OW-1:0];
        if (shifted > MAXV) begin
            q_o = MAXV[OW-1:0];
        end else if (shifted < MINV) begin
            q_o = MINV[OW-1:0];
        end
    end

endmodule

// File: rtl/quantize_seq.sv
// Quantizes one skewed anti-diagonal per accepted beat and tags it with the diagonal
// number and set number so the write-out stage can steer it to the right SRAM.
module quantize_seq
    import quantize_seq_pkg::*;
#(
    parameter int ARRAY_SIZE        = 32,
    parameter int ACC_WIDTH         = 32,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int SHIFT             = 8,
    parameter int NUM_SETS          = 2
) (
    input  logic                                    clk,
    input  logic                                    srstn,
    input  logic                                    start,
    input  logic                                    acc_valid,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]         acc_data,
    output logic                                    sram_write_enable,
    output logic [DATA_SET_W-1:0]                   data_set,
    output logic [MATRIX_INDEX_W-1:0]               matrix_index,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
    output logic                                    busy,
    output logic                                    done
);

    localparam int QW = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam logic [MATRIX_INDEX_W-1:0] LAST_DIAG = MATRIX_INDEX_W'(max_diag(ARRAY_SIZE));
    localparam logic [DATA_SET_W-1:0]     LAST_SET  = DATA_SET_W'(NUM_SETS - 1);

    // Handshake: there is no backpressure. A beat is taken on every posedge where the
    // FSM is in RUN and acc_valid is high; its result appears exactly one cycle later
    // with sram_write_enable high. acc_valid outside RUN is dropped.

    state_e                    state_q, state_d;
    logic [MATRIX_INDEX_W-1:0] diag_q, diag_d;
    logic [DATA_SET_W-1:0]     set_q, set_d;
    logic                      we_q, we_d;
    logic                      done_q, done_d;
    logic [QW-1:0]             qdata_q, qdata_d;
    logic [MATRIX_INDEX_W-1:0] midx_q, midx_d;
    logic [DATA_SET_W-1:0]     dset_q, dset_d;
    logic [QW-1:0]             lane_q;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        quant_lane #(
            .ACC_WIDTH         (ACC_WIDTH),
            .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH),
            .SHIFT             (SHIFT)
        ) u_lane (
            .acc_i (acc_data[i*ACC_WIDTH +: ACC_WIDTH]),
            .q_o   (lane_q[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= IDLE;
            diag_q  <= '0;
            set_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            qdata_q <= '0;
            midx_q  <= '0;
            dset_q  <= '0;
        end else begin
            state_q <= state_d;
            diag_q  <= diag_d;
            set_q   <= set_d;
            we_q    <= we_d;
            done_q  <= done_d;
            qdata_q <= qdata_d;
            midx_q  <= midx_d;
            dset_q  <= dset_d;
        end
    end

    always_comb begin
        state_d = state_q;
        diag_d  = diag_q;
        set_d   = set_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        qdata_d = qdata_q;
        midx_d  = midx_q;
        dset_d  = dset_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    diag_d  = '0;
                    set_d   = '0;
                end
            end
            RUN: begin
                if (acc_valid) begin
                    we_d    = 1'b1;
                    qdata_d = lane_q;
                    midx_d  = diag_q;
                    dset_d  = set_q;
                    if (diag_q == LAST_DIAG) begin
                        diag_d = '0;
                        if (set_q == LAST_SET) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            set_d = set_q + 1'b1;
                        end
                    end else begin
                        diag_d = diag_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sram_write_enable = we_q;
    assign done              = done_q;
    assign quantized_data    = qdata_q;
    assign matrix_index      = midx_q;
    assign data_set          = dset_q;
    assign busy              = (state_q == RUN);

endmodule

// File: doc/quantize_seq.md
Name: quantize_seq

Overview:
- Stage directly upstream of the SRAM write-out stage.
- Accepts one skewed anti-diagonal of raw accumulator results per valid cycle from the systolic array.
- Rescales each lane with a rounding arithmetic right shift, then saturates it to OUTPUT_DATA_WIDTH.
- Sequences matrix_index/data_set so the write-out stage can steer each diagonal to SRAM a/b/c.

Parameters:
ARRAY_SIZE, 32, lanes per diagonal (systolic array dimension)
ACC_WIDTH, 32, signed accumulator width per lane
OUTPUT_DATA_WIDTH, 16, signed quantized width per lane
SHIFT, 8, right-shift amount (legal range 1..ACC_WIDTH-1)
NUM_SETS, 2, data sets per run (legal range 1..4)

Ports:
clk  in  1  clock
srstn  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a run when idle
acc_valid  in  1  acc_data holds one diagonal this cycle
acc_data  in  ARRAY_SIZE*ACC_WIDTH  signed lanes; lane i at [i*ACC_WIDTH +: ACC_WIDTH]
sram_write_enable  out  1  quantized_data/matrix_index/data_set are valid this cycle
data_set  out  2  set number of the current diagonal
matrix_index  out  6  diagonal number 0..2*ARRAY_SIZE-2
quantized_data  out  ARRAY_SIZE*OUTPUT_DATA_WIDTH  signed lanes; lane i at [i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]
busy  out  1  high while in RUN
done  out  1  one-cycle pulse coincident with the final write

Behaviour:
- Reset (srstn=0 at posedge): every output, counter and the state register goes to 0; state becomes IDLE. Reset mid-run aborts the run with no done pulse.
- States: IDLE, RUN.
- IDLE:
  - acc_valid is ignored; sram_write_enable=0.
  - start=1 -> RUN; diag_cnt=0, set_cnt=0.
  - The start cycle itself accepts no data.
- RUN:
  - acc_valid=1 at posedge -> next cycle: sram_write_enable=1, quantized_data=Q(acc_data), matrix_index=diag_cnt, data_set=set_cnt. Latency is exactly 1 cycle.
  - acc_valid=0 -> next cycle: sram_write_enable=0; quantized_data, matrix_index and data_set hold their values.
  - Counter update on each accepted beat:
    - diag_cnt < 2*ARRAY_SIZE-2: diag_cnt+1.
    - diag_cnt == 2*ARRAY_SIZE-2: diag_cnt wraps to 0, then
      - if set_cnt < NUM_SETS-1: set_cnt+1;
      - otherwise: go to IDLE and assert done for one cycle together with that final sram_write_enable.
- start while busy is ignored; it never restarts or corrupts counters.
- busy = (state==RUN), registered.
- Q(v), per lane, for signed v:
  - t = (v + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_WIDTH+1 bits (no overflow on the add).
  - Saturate t to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1].
  - Rounding is round-half-up toward +inf (e.g. -1.5 -> -1).
- All lanes are quantized unconditionally. The write-out stage zeroes unused lanes; this block does not.
- One run = NUM_SETS*(2*ARRAY_SIZE-1) accepted beats (126 at defaults).

Decomposition:
- Shared package:
  - localparam MAX_DIAG = 2*ARRAY_SIZE-2.
  - State enum IDLE/RUN.
  - Widths of matrix_index (6) and data_set (2), also used by the write-out stage.
- Sub-module: quant_lane (one lane's round+shift+saturate, purely combinational), generated ARRAY_SIZE times. Registering happens in quantize_seq.

Test Plan:
- Rounding, lane 0: acc=384 -> 2; acc=-384 -> -1; acc=127 -> 0; acc=128 -> 1; all with 1-cycle latency and sram_write_enable=1.
- Saturation: acc=0x7FFFFFFF -> 32767; acc=0x80000000 -> -32768; acc=8388480 -> 32767; all lanes checked independently.
- Full run:
  - start, then 126 back-to-back valid beats.
  - Required outputs: matrix_index 0..62 with data_set=0, then 0..62 with data_set=1.
  - done high only on the 126th write; busy drops the next cycle.
- Bubbles:
  - Insert acc_valid=0 gaps at index 10 and at the set boundary (index 62).
  - Required: sram_write_enable=0 during gaps, outputs held, index sequence unchanged.
- Illegal/overlap:
  - start pulsed at index 30: no effect.
  - acc_valid in IDLE: no write.
  - acc_valid on the start cycle: not accepted.
- Reset mid-run: srstn=0 at index 40 of set 1 -> all outputs 0, busy=0, no done; a new start restarts at index 0, set 0.
